// File: rtl/wb_frontport_pkg.sv
// Shared constants for the frontport Wishbone master: opcodes, status bytes,
// FSM state encoding and the response-frame builder.
package wb_frontport_pkg;

  localparam logic [7:0] OP_PING   = 8'h50;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] OP_WRITE  = 8'h57;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_ERR    = 8'h01;
  localparam logic [7:0] ST_TMO    = 8'h02;
  localparam logic [7:0] ST_BADCMD = 8'hFF;
  localparam logic [7:0] PING_RESP = 8'hA5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_BUS  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  typedef struct packed {
    logic [2:0]  len;
    logic [39:0] bytes;
  } resp_t;

  // Bytes go out LSB first: read data little-endian, then the status byte.
  function automatic resp_t make_resp(input logic is_write, input logic [7:0] status,
                                      input logic [31:0] data);
    resp_t r;
    if (is_write) begin
      r.len   = 3'd1;
      r.bytes = {32'h0, status};
    end else begin
      r.len   = 3'd5;
      r.bytes = {status, data};
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_frontport_if.sv
// Host byte-link and Wishbone signals of the frontport master, grouped in one bundle.
interface wb_frontport_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i, wb_err_i,
    output rx_ready_o, tx_data_o, tx_valid_o, wb_adr_o, wb_dat_o, wb_we_o,
           wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i, wb_err_i,
    input  rx_ready_o, tx_data_o, tx_valid_o, wb_adr_o, wb_dat_o, wb_we_o,
           wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_frontport_txser.sv
// Response serializer: loads up to 5 bytes with a length and shifts them out
// LSB first over a registered valid/ready handshake.
module wb_frontport_txser (
  input  logic        clk,
  input  logic        srst,
  input  logic        load,
  input  logic [39:0] load_bytes,
  input  logic [2:0]  load_len,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        last
);

  logic [39:0] shift_reg;
  logic [2:0]  cnt_reg;
  logic        valid_reg;
  logic        fire;

  assign fire  = valid_reg & ready;
  assign last  = fire & (cnt_reg == 3'd1);
  assign data  = shift_reg[7:0];
  assign valid = valid_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_bytes;
      cnt_reg   <= load_len;
      valid_reg <= (load_len != 3'd0);
    end else if (fire) begin
      shift_reg <= {8'h00, shift_reg[39:8]};
      cnt_reg   <= cnt_reg - 3'd1;
      valid_reg <= (cnt_reg != 3'd1);
    end
  end

endmodule

// File: rtl/wb_frontport_master.sv
// Frontport Wishbone master: parses host command frames into single classic
// Wishbone transfers and returns data/status over the response byte stream.
module wb_frontport_master
  import wb_frontport_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  wb_frontport_if.master   fp
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [2:0]       state_reg, state_next;
  logic [1:0]       idx_reg;
  logic             is_write_reg;
  logic             rx_ready_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [31:0]      adr_reg, dat_reg;
  logic             we_reg, cyc_reg, stb_reg;
  logic [3:0]       sel_reg;

  logic             rx_fire;
  logic             tmo_hit;
  logic             resp_load;
  resp_t            resp_next;
  logic             tx_last;

  assign rx_fire = fp.rx_valid_i & rx_ready_reg;
  // The counter holds the number of completed BUS cycles, so the abort lands
  // exactly TIMEOUT_CYCLES cycles after cyc rose.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_reg == TMO_LAST);

  always_comb begin
    state_next = state_reg;
    resp_load  = 1'b0;
    resp_next  = '0;
    case (state_reg)
      S_IDLE: begin
        if (rx_fire) begin
          if (fp.rx_data_i == OP_READ || fp.rx_data_i == OP_WRITE) begin
            state_next = S_ADDR;
          end else begin
            state_next      = S_RESP;
            resp_load       = 1'b1;
            resp_next.len   = 3'd1;
            resp_next.bytes = {32'h0, (fp.rx_data_i == OP_PING) ? PING_RESP : ST_BADCMD};
          end
        end
      end
      S_ADDR: begin
        if (rx_fire && idx_reg == 2'd3) state_next = is_write_reg ? S_DATA : S_BUS;
      end
      S_DATA: begin
        if (rx_fire && idx_reg == 2'd3) state_next = S_BUS;
      end
      S_BUS: begin
        // err has priority over a simultaneous ack; failed reads return zero data
        if (fp.wb_err_i) begin
          state_next = S_RESP;
          resp_load  = 1'b1;
          resp_next  = make_resp(is_write_reg, ST_ERR, 32'h0);
        end else if (fp.wb_ack_i) begin
          state_next = S_RESP;
          resp_load  = 1'b1;
          resp_next  = make_resp(is_write_reg, ST_OK, fp.wb_dat_i);
        end else if (tmo_hit) begin
          state_next = S_RESP;
          resp_load  = 1'b1;
          resp_next  = make_resp(is_write_reg, ST_TMO, 32'h0);
        end
      end
      S_RESP: begin
        if (tx_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 2'd0;
      is_write_reg <= 1'b0;
      rx_ready_reg <= 1'b0;
      tmo_cnt_reg  <= '0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      we_reg       <= 1'b0;
      sel_reg      <= 4'h0;
      cyc_reg      <= 1'b0;
      stb_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_ready_reg <= (state_next == S_IDLE) || (state_next == S_ADDR) || (state_next == S_DATA);

      if (rx_fire) begin
        case (state_reg)
          S_IDLE: begin
            is_write_reg <= (fp.rx_data_i == OP_WRITE);
            idx_reg      <= 2'd0;
          end
          S_ADDR: begin
            adr_reg[{idx_reg, 3'b000} +: 8] <= fp.rx_data_i;
            idx_reg <= idx_reg + 2'd1;
          end
          S_DATA: begin
            dat_reg[{idx_reg, 3'b000} +: 8] <= fp.rx_data_i;
            idx_reg <= idx_reg + 2'd1;
          end
          default: ;
        endcase
      end

      if (state_reg != S_BUS && state_next == S_BUS) begin
        cyc_reg     <= 1'b1;
        stb_reg     <= 1'b1;
        we_reg      <= is_write_reg;
        sel_reg     <= 4'hF;
        tmo_cnt_reg <= '0;
      end else if (state_reg == S_BUS) begin
        if (state_next != S_BUS) begin
          cyc_reg <= 1'b0;
          stb_reg <= 1'b0;
          we_reg  <= 1'b0;
          sel_reg <= 4'h0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end
    end
  end

  wb_frontport_txser u_txser (
    .clk        (wb_clk_i),
    .srst       (wb_rst_i),
    .load       (resp_load),
    .load_bytes (resp_next.bytes),
    .load_len   (resp_next.len),
    .data       (fp.tx_data_o),
    .valid      (fp.tx_valid_o),
    .ready      (fp.tx_ready_i),
    .last       (tx_last)
  );

  assign fp.rx_ready_o = rx_ready_reg;
  assign fp.wb_adr_o   = adr_reg;
  assign fp.wb_dat_o   = dat_reg;
  assign fp.wb_we_o    = we_reg;
  assign fp.wb_sel_o   = sel_reg;
  assign fp.wb_stb_o   = stb_reg;
  assign fp.wb_cyc_o   = cyc_reg;

endmodule

// File: tb/tb_wb_frontport_master.sv
// Directed bench for wb_frontport_master: ping, read, write, error, timeout,
// unknown opcode, tx backpressure and mid-frame reset.
module tb_wb_frontport_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_frontport_if fp ();

  wb_frontport_master #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .fp       (fp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns in the cycle right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    fp.rx_data_i  = b;
    fp.rx_valid_i = 1'b1;
    while (!fp.rx_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk("rx_accept_timeout", {31'h0, fp.rx_ready_o}, 32'h1);
    tick();
    fp.rx_valid_i = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n = 0;
    fp.tx_ready_i = 1'b1;
    while (!fp.tx_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'h0, fp.tx_valid_o}, 32'h1);
    chk(tag, {24'h0, fp.tx_data_o}, {24'h0, exp});
    tick();
    fp.tx_ready_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] adr);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(adr[i*8 +: 8]);
  endtask

  task automatic recv_read_resp(input string tag, input logic [31:0] d, input logic [7:0] st);
    for (int i = 0; i < 4; i++) recv_byte($sformatf("%s_d%0d", tag, i), d[i*8 +: 8]);
    recv_byte({tag, "_st"}, st);
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_cyc"}, {31'h0, fp.wb_cyc_o}, 32'h0);
    chk({tag, "_stb"}, {31'h0, fp.wb_stb_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic stable;
    fp.rx_data_i  = 8'h00;
    fp.rx_valid_i = 1'b0;
    fp.tx_ready_i = 1'b0;
    fp.wb_dat_i   = 32'h0;
    fp.wb_ack_i   = 1'b0;
    fp.wb_err_i   = 1'b0;
    tick();
    tick();
    chk("rst_rx_ready", {31'h0, fp.rx_ready_o}, 32'h0);
    chk("rst_tx_valid", {31'h0, fp.tx_valid_o}, 32'h0);
    chk("rst_tx_data", {24'h0, fp.tx_data_o}, 32'h0);
    chk("rst_sel", {28'h0, fp.wb_sel_o}, 32'h0);
    chk("rst_adr", fp.wb_adr_o, 32'h0);
    chk_idle_bus("rst");
    rst = 1'b0;
    tick();
    chk("idle_rx_ready", {31'h0, fp.rx_ready_o}, 32'h1);

    // Ping
    send_byte(8'h50);
    chk_idle_bus("ping");
    recv_byte("ping_resp", 8'hA5);
    chk("ping_rx_ready_after", {31'h0, fp.rx_ready_o}, 32'h1);
    $display("txn ping: rx 50 -> tx A5");

    // Write, slave acks three cycles after stb
    send_frame(8'h57, 32'h2000_0000);
    for (int i = 0; i < 4; i++) send_byte(8'hEF - 8'h00 + 8'h00 == 8'hEF && i == 0 ? 8'hEF :
                                          (i == 1 ? 8'hBE : (i == 2 ? 8'hAD : 8'hDE)));
    chk("wr_cyc", {31'h0, fp.wb_cyc_o}, 32'h1);
    chk("wr_stb", {31'h0, fp.wb_stb_o}, 32'h1);
    chk("wr_we", {31'h0, fp.wb_we_o}, 32'h1);
    chk("wr_sel", {28'h0, fp.wb_sel_o}, 32'hF);
    chk("wr_adr", fp.wb_adr_o, 32'h2000_0000);
    chk("wr_dat", fp.wb_dat_o, 32'hDEAD_BEEF);
    chk("wr_rx_ready", {31'h0, fp.rx_ready_o}, 32'h0);
    repeat (3) tick();
    chk("wr_cyc_wait", {31'h0, fp.wb_cyc_o}, 32'h1);
    fp.wb_ack_i = 1'b1;
    tick();
    fp.wb_ack_i = 1'b0;
    chk_idle_bus("wr_done");
    chk("wr_tx_valid_at_ack", {31'h0, fp.tx_valid_o}, 32'h1);
    recv_byte("wr_status", 8'h00);
    $display("txn write: adr 20000000 dat DEADBEEF -> status 00");

    // Read with immediate ack
    send_frame(8'h52, 32'h2000_0004);
    chk("rd_adr", fp.wb_adr_o, 32'h2000_0004);
    chk("rd_we", {31'h0, fp.wb_we_o}, 32'h0);
    chk("rd_cyc", {31'h0, fp.wb_cyc_o}, 32'h1);
    fp.wb_dat_i = 32'h1234_5678;
    fp.wb_ack_i = 1'b1;
    tick();
    fp.wb_ack_i = 1'b0;
    fp.wb_dat_i = 32'h0;
    chk_idle_bus("rd_done");
    recv_read_resp("rd", 32'h1234_5678, 8'h00);
    $display("txn read: adr 20000004 -> 12345678 status 00");

    // Timeout: nobody answers
    send_frame(8'h52, 32'h3000_0000);
    begin
      int n = 0;
      while (fp.wb_cyc_o && n < 100) begin
        n++;
        tick();
      end
      chk("tmo_cyc_cycles", n, 32'd16);
    end
    fp.wb_dat_i = 32'h5555_AAAA;
    fp.wb_ack_i = 1'b1;
    tick();
    fp.wb_ack_i = 1'b0;
    fp.wb_dat_i = 32'h0;
    chk_idle_bus("tmo_late_ack");
    recv_read_resp("tmo", 32'h0, 8'h02);
    $display("txn read timeout: 16 cycles -> status 02");

    // Write with ack and err together
    send_frame(8'h57, 32'h4000_0010);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("werr_dat", fp.wb_dat_o, 32'h0403_0201);
    fp.wb_ack_i = 1'b1;
    fp.wb_err_i = 1'b1;
    tick();
    fp.wb_ack_i = 1'b0;
    fp.wb_err_i = 1'b0;
    chk_idle_bus("werr_done");
    recv_byte("werr_status", 8'h01);
    $display("txn write ack+err -> status 01");

    // Read with bus error: data bytes forced to zero
    send_frame(8'h52, 32'h4000_0020);
    fp.wb_dat_i = 32'hFFFF_FFFF;
    fp.wb_err_i = 1'b1;
    tick();
    fp.wb_err_i = 1'b0;
    fp.wb_dat_i = 32'h0;
    recv_read_resp("rerr", 32'h0, 8'h01);
    $display("txn read err -> 00000000 status 01");

    // Unknown opcode
    send_byte(8'h3F);
    chk_idle_bus("bad");
    recv_byte("bad_resp", 8'hFF);
    $display("txn unknown opcode 3F -> FF");

    // tx backpressure: first byte must hold for 10 cycles
    send_frame(8'h52, 32'h0000_0100);
    fp.wb_dat_i = 32'hCAFE_F00D;
    fp.wb_ack_i = 1'b1;
    tick();
    fp.wb_ack_i = 1'b0;
    fp.wb_dat_i = 32'h0;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (fp.tx_data_o !== 8'h0D || fp.tx_valid_o !== 1'b1) stable = 1'b0;
      tick();
    end
    chk("hold_stable", {31'h0, stable}, 32'h1);
    recv_read_resp("hold", 32'hCAFE_F00D, 8'h00);
    $display("txn read with tx stall -> CAFEF00D status 00");

    // Reset after two address bytes
    send_byte(8'h52);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_rx_ready", {31'h0, fp.rx_ready_o}, 32'h0);
    chk("mrst_tx_valid", {31'h0, fp.tx_valid_o}, 32'h0);
    chk("mrst_adr", fp.wb_adr_o, 32'h0);
    chk("mrst_dat", fp.wb_dat_o, 32'h0);
    chk("mrst_we", {31'h0, fp.wb_we_o}, 32'h0);
    chk_idle_bus("mrst");
    send_byte(8'h50);
    recv_byte("mrst_ping", 8'hA5);
    $display("txn reset mid-frame then ping -> A5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
